// File: rtl/mul_acc_unit_pkg.sv
// mul_acc_unit_pkg -- shared definitions for the iterative multiply/accumulate unit.
//   * op_i encodings (MULT, MULTU, MADD, MADDU, MSUB, MSUBU; 3'd6/3'd7 undefined)
//   * FSM state encoding
//   * MULACC_ZERO_SKIP_EN guard: define it to enable the zero-operand early-out.
package mul_acc_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

`ifdef MULACC_ZERO_SKIP_EN
    localparam bit ZERO_SKIP_EN = 1'b1;
`else
    localparam bit ZERO_SKIP_EN = 1'b0;
`endif

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mul_acc_step.sv
// mul_acc_step -- combinational shift-add step retiring BITS multiplier bits.
//   prod     : running partial product (2*DATA_W)
//   mcand    : multiplicand already aligned to the current bit group (2*DATA_W)
//   bits     : current BITS-wide multiplier group, LSB first
//   prod_nxt : prod + sum(bits[j] ? mcand << j), wrapping at 2*DATA_W
module mul_acc_step #(
    parameter int DATA_W = 32,
    parameter int BITS   = 4
) (
    input  logic [2*DATA_W-1:0] prod,
    input  logic [2*DATA_W-1:0] mcand,
    input  logic [BITS-1:0]     bits,
    output logic [2*DATA_W-1:0] prod_nxt
);

    always_comb begin
        prod_nxt = prod;
        for (int j = 0; j < BITS; j++) begin
            if (bits[j])
                prod_nxt = prod_nxt + (mcand << j);
        end
    end

endmodule

// File: rtl/mul_acc_unit.sv
// mul_acc_unit -- iterative MULT/MADD/MSUB unit (signed and unsigned forms).
// Magnitudes are multiplied BITS_PER_CYCLE bits per cycle; the sign and the
// accumulator are applied in a single ACC cycle at the end.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : request an operation (sampled in IDLE; holds DONE)
//   annul_i      : flush, returns to IDLE and clears outputs
//   op_i         : operation code (see mul_acc_unit_pkg)
//   opdata1_i/2_i: multiplicand / multiplier
//   hi_i, lo_i   : forwarded accumulator
//   result_o     : {HI,LO} result, ready_o marks it valid
//   busy_o       : high in MUL and ACC
// Build option: MULACC_ZERO_SKIP_EN enables the zero-operand early-out.
module mul_acc_unit
    import mul_acc_unit_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    state_t                state_q;
    logic [2:0]            op_q;
    logic                  neg_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [2*DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]     mplier_q;
    logic [2*DATA_W-1:0]   prod_q;
    logic [CNT_W-1:0]      cnt_q;

    // capture-side operand conditioning
    logic                  sgn;
    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     mag_a, mag_b;
    logic                  zero_op;

    always_comb begin
        sgn     = op_is_signed(op_i);
        a_neg   = sgn & opdata1_i[DATA_W-1];
        b_neg   = sgn & opdata2_i[DATA_W-1];
        mag_a   = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        mag_b   = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
        zero_op = (opdata1_i == '0) || (opdata2_i == '0);
    end

    logic [2*DATA_W-1:0] step_sum;

    mul_acc_step #(
        .DATA_W (DATA_W),
        .BITS   (BITS_PER_CYCLE)
    ) u_step (
        .prod     (prod_q),
        .mcand    (mcand_q),
        .bits     (mplier_q[BITS_PER_CYCLE-1:0]),
        .prod_nxt (step_sum)
    );

    // final sign fix-up and accumulate
    logic [2*DATA_W-1:0] prod_sgn;
    logic [2*DATA_W-1:0] acc_res;

    always_comb begin
        prod_sgn = neg_q ? (~prod_q + 1'b1) : prod_q;
        case (op_q)
            OP_MULT, OP_MULTU: acc_res = prod_sgn;
            OP_MADD, OP_MADDU: acc_res = acc_q + prod_sgn;
            OP_MSUB, OP_MSUBU: acc_res = acc_q - prod_sgn;
            default:           acc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else if (annul_i) begin
            state_q  <= ST_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q     <= op_i;
                        neg_q    <= a_neg ^ b_neg;
                        acc_q    <= {hi_i, lo_i};
                        mcand_q  <= {{DATA_W{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        prod_q   <= '0;
                        busy_o   <= 1'b1;
                        state_q  <= ST_MUL;
                        // Early-out: the product is already zero, so jump the
                        // counter to its last iteration; one MUL pass then ACC.
                        if (ZERO_SKIP_EN && zero_op)
                            cnt_q <= CNT_W'(N - 1);
                        else
                            cnt_q <= '0;
                    end
                end
                ST_MUL: begin
                    prod_q   <= step_sum;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N - 1))
                        state_q <= ST_ACC;
                end
                ST_ACC: begin
                    result_o <= acc_res;
                    ready_o  <= 1'b1;
                    busy_o   <= 1'b0;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    // start_i held high keeps the result presented
                    if (!start_i) begin
                        ready_o <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_acc_unit.sv
module tb_mul_acc_unit;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i, annul_i;
    logic [2:0]      op_i;
    logic [DW-1:0]   opdata1_i, opdata2_i, hi_i, lo_i;
    logic [2*DW-1:0] result_o;
    logic            ready_o, busy_o;

    int total = 0;
    int bad   = 0;
    int cyc;

`ifdef MULACC_ZERO_SKIP_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 9;
`endif

    mul_acc_unit #(.DATA_W(DW), .BITS_PER_CYCLE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hi_i      (hi_i),
        .lo_i      (lo_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request on a falling edge; return on the falling edge right
    // after the capturing rising edge.
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] h, input logic [DW-1:0] l, input bit hold);
        @(negedge clk);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l; start_i = 1'b1;
        @(negedge clk);
        if (!hold) start_i = 1'b0;
    endtask

    // Count rising edges until ready_o, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        rst = 1'b0;

        // MULT -1 x 2
        issue(3'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b0);
        chk("mult_busy", 64'(busy_o), 64'd1);
        wait_ready(cyc);
        chk("mult_lat", 64'(cyc), 64'd9);
        chk("mult_res", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mult_busy_done", 64'(busy_o), 64'd0);

        // MADDU max x max + 1, inputs scrambled after capture
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        opdata1_i = 32'h0; opdata2_i = 32'h7; hi_i = 32'hDEAD; lo_i = 32'hBEEF;
        wait_ready(cyc);
        chk("maddu_lat", 64'(cyc), 64'd9);
        chk("maddu_res", result_o, 64'hFFFF_FFFE_0000_0002);

        // MSUB 3 x 4 from 0, start held through DONE
        issue(3'd4, 32'd3, 32'd4, 32'h0, 32'h0, 1'b1);
        wait_ready(cyc);
        chk("msub_lat", 64'(cyc), 64'd9);
        chk("msub_res", result_o, 64'hFFFF_FFFF_FFFF_FFF4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("msub_hold_rdy", 64'(ready_o), 64'd1);
            chk("msub_hold_res", result_o, 64'hFFFF_FFFF_FFFF_FFF4);
        end
        start_i = 1'b0;
        @(negedge clk);
        chk("msub_idle_rdy", 64'(ready_o), 64'd0);
        chk("msub_idle_busy", 64'(busy_o), 64'd0);

        // annul during 4th MUL cycle
        issue(3'd1, 32'd11, 32'd13, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("annul_pre_busy", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'd0);

        // MULTU 5 x 6 with an ignored second start mid-operation
        issue(3'd1, 32'd5, 32'd6, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        op_i = 3'd0; opdata1_i = 32'd7; opdata2_i = 32'd9; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_ready(cyc);
        chk("multu_lat", 64'(cyc), 64'd5);
        chk("multu_res", result_o, 64'd30);

        // reset during ACC (result still holds 30 from above)
        issue(3'd0, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0);
        repeat (8) @(negedge clk);
        chk("acc_busy", 64'(busy_o), 64'd1);
        chk("acc_ready", 64'(ready_o), 64'd0);
        rst = 1'b1; start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        chk("rstacc_ready", 64'(ready_o), 64'd0);
        chk("rstacc_busy", 64'(busy_o), 64'd0);
        chk("rstacc_result", result_o, 64'd0);

        // annul beats start in IDLE
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; op_i = 3'd1; opdata1_i = 32'd2; opdata2_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        chk("annul_prio_busy", 64'(busy_o), 64'd0);

        // zero operand
        issue(3'd1, 32'd0, 32'h1234, 32'h0, 32'h0, 1'b0);
        wait_ready(cyc);
        chk("zero_lat", 64'(cyc), 64'(ZLAT));
        chk("zero_res", result_o, 64'd0);

        // signed MADD: -3 x 5 + 20 = 5
        issue(3'd2, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'd20, 1'b0);
        wait_ready(cyc);
        chk("madd_res", result_o, 64'd5);

        // MULT -7 x -6 = 42
        issue(3'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0, 32'h0, 1'b0);
        wait_ready(cyc);
        chk("mult_nn_res", result_o, 64'd42);

        // MSUBU 0x1_00000000 - 2 x 3
        issue(3'd5, 32'd2, 32'd3, 32'h1, 32'h0, 1'b0);
        wait_ready(cyc);
        chk("msubu_res", result_o, 64'h0000_0000_FFFF_FFFA);

        // MULTU of 0x80000000 x 0x80000000 (no sign handling for unsigned)
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        wait_ready(cyc);
        chk("multu_big_res", result_o, 64'h4000_0000_0000_0000);

        // undefined op -> zero with normal latency
        issue(3'd7, 32'd5, 32'd6, 32'h1, 32'h1, 1'b0);
        wait_ready(cyc);
        chk("undef_lat", 64'(cyc), 64'd9);
        chk("undef_res", result_o, 64'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_acc_unit.md
MUL_ACC_UNIT -- requirements
Module: mul_acc_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: operand width; even, >= 8.
REQ-002 The block SHALL have parameter BITS_PER_CYCLE, default 4: multiplier bits retired per iteration; one of 1, 2, 4, 8; must divide DATA_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port annul_i, input, 1 bit: abort any operation in progress (branch flush).
REQ-007 The block SHALL have port op_i, input, 3 bits: operation code (MULT, MULTU, MADD, MADDU, MSUB, MSUBU).
REQ-008 The block SHALL have ports opdata1_i and opdata2_i, input, DATA_W bits each: multiplicand and multiplier.
REQ-009 The block SHALL have ports hi_i and lo_i, input, DATA_W bits each: forwarded accumulator {HI,LO}.
REQ-010 The block SHALL have port result_o, output, 2*DATA_W bits: final {HI,LO}.
REQ-011 The block SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-012 The block SHALL have port busy_o, output, 1 bit: operation in flight, so EX holds its stall request.

Function
REQ-013 The block SHALL implement FSM states IDLE, MUL, ACC and DONE, with N = DATA_W/BITS_PER_CYCLE.
REQ-014 In IDLE with start_i=1 and annul_i=0, the block SHALL capture op_i, operand magnitudes, product sign and {hi_i,lo_i}, clear the iteration counter, and go to MUL.
REQ-015 MUL SHALL add BITS_PER_CYCLE partial products per cycle and go to ACC after exactly N iterations.
REQ-016 ACC SHALL apply the product sign, add (MADD*) or subtract (MSUB*) the captured accumulator, or pass the product through (MULT*), register result_o, and go to DONE.
REQ-017 Latency: start sampled at edge k SHALL give ready_o=1 after edge k+N+1 (9 cycles at the defaults).
REQ-018 DONE SHALL hold ready_o=1 and result_o stable while start_i=1, and SHALL go to IDLE on the first edge with start_i=0.
REQ-019 busy_o SHALL be 1 in MUL and ACC and 0 in IDLE and DONE.
REQ-020 Signed ops (MULT, MADD, MSUB) SHALL treat operands as two's complement; unsigned ops SHALL treat them as magnitudes.
REQ-021 All 2*DATA_W arithmetic SHALL wrap modulo 2^(2*DATA_W), with no overflow indication.
REQ-022 annul_i=1 in any state SHALL force IDLE on the next edge, clear ready_o and result_o, and take priority over start_i in the same cycle.
REQ-023 start_i while in MUL or ACC SHALL be ignored; operand and accumulator changes after capture SHALL have no effect.
REQ-024 An undefined op_i SHALL produce result_o=0 with normal latency.

Reset
REQ-025 rst=1 SHALL put the FSM in IDLE and set result_o=0, ready_o=0, busy_o=0, counter=0 on the next edge, including mid-operation.
REQ-026 rst SHALL take priority over annul_i and start_i.

Configuration
REQ-027 The macro MULACC_ZERO_SKIP_EN SHALL control early-out on zero operands.
REQ-028 With MULACC_ZERO_SKIP_EN defined, a zero opdata1_i or opdata2_i at capture SHALL skip MUL and go straight to ACC with product 0, so ready_o=1 after edge k+2.
REQ-029 Without MULACC_ZERO_SKIP_EN, zero operands SHALL take the full N+1 latency.

Structure
REQ-030 The op_i encodings, FSM state encodings and the MULACC_ZERO_SKIP_EN guard SHALL live in the shared defines file.
REQ-031 The BITS_PER_CYCLE shift-add step SHALL be a combinational sub-module named mul_acc_step, instantiated once.

Verification
REQ-032 MULT 0xFFFFFFFF x 0x00000002 -> ready_o=1 after 9 cycles; result_o=0xFFFFFFFF_FFFFFFFE.
REQ-033 MADDU 0xFFFFFFFF x 0xFFFFFFFF with hi_i=0, lo_i=1 -> result_o=0xFFFFFFFE_00000002.
REQ-034 MSUB 3 x 4 with accumulator 0 -> result_o=0xFFFFFFFF_FFFFFFF4; start_i held high 3 more cycles -> ready_o and result_o stable; start_i low -> IDLE next edge.
REQ-035 annul_i during the 4th MUL cycle -> busy_o=0 and ready_o=0 next edge; then MULTU 5 x 6 -> result_o=30 after 9 cycles; a second start_i with other operands mid-operation does not change the result.
REQ-036 MULTU 0 x 0x1234 -> ready_o after 2 cycles with MULACC_ZERO_SKIP_EN, after 9 cycles without; result_o=0 in both cases.
REQ-037 rst asserted during ACC -> next edge: IDLE, result_o=0, ready_o=0, busy_o=0.
